// File: rtl/gated_det_counter.sv
// Gated detector-pulse counter: integrates in-gate events over N gate windows.
// Define GATED_DET_DARK_COUNT_EN to add an out-of-gate (dark) accumulator.
module gated_det_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        det_gate,
  input  logic        det_in,
  input  logic [15:0] integ_periods,
  output logic [31:0] count_data,
  output logic        count_sat,
  output logic        count_valid,
  input  logic        count_ready,
  output logic        overrun
`ifdef GATED_DET_DARK_COUNT_EN
  ,
  output logic [31:0] dark_data
`endif
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_e;
  localparam logic [31:0] ACC_MAX = '1;

  logic [SYNC_STAGES-1:0] det_sync_q, det_sync_d;
  logic [SYNC_STAGES-1:0] gate_sync_q, gate_sync_d;
  logic        det_edge_q, det_edge_d;
  logic        gate_dly_q, gate_dly_d;
  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic        sat_q, sat_d;
  logic [15:0] win_q, win_d;
  logic [15:0] tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic [31:0] res_cnt_q, res_cnt_d;
  logic        res_sat_q, res_sat_d;
  logic [31:0] count_data_q, count_data_d;
  logic        count_sat_q, count_sat_d;
  logic        count_valid_q, count_valid_d;
  logic        overrun_q, overrun_d;
`ifdef GATED_DET_DARK_COUNT_EN
  logic [31:0] dark_q, dark_d;
  logic [31:0] res_dark_q, res_dark_d;
  logic [31:0] dark_data_q, dark_data_d;
`endif

  logic        ev;
  logic        gate_a;
  logic        wend;
  logic [15:0] tgt_now;

  assign ev      = det_sync_q[SYNC_STAGES-1] & ~det_edge_q;
  assign gate_a  = gate_sync_q[SYNC_STAGES-1];
  assign wend    = gate_dly_q & ~gate_a;
  assign tgt_now = (integ_periods == 16'd0) ? 16'd1 : integ_periods;

  always_comb begin
    det_sync_d  = {det_sync_q[SYNC_STAGES-2:0], det_in};
    gate_sync_d = {gate_sync_q[SYNC_STAGES-2:0], det_gate};
    det_edge_d  = det_sync_q[SYNC_STAGES-1];
    gate_dly_d  = gate_a;
    state_d     = state_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    win_d       = win_q;
    tgt_d       = tgt_q;
    pend_d      = 1'b0;
    res_cnt_d   = res_cnt_q;
    res_sat_d   = res_sat_q;
`ifdef GATED_DET_DARK_COUNT_EN
    dark_d      = dark_q;
    res_dark_d  = res_dark_q;
`endif
    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        sat_d = 1'b0;
        win_d = '0;
`ifdef GATED_DET_DARK_COUNT_EN
        dark_d = '0;
`endif
        if (enable) state_d = ARM;
      end
      ARM: begin
        // never start inside a window we only saw part of
        if (!gate_a) begin
          state_d = RUN;
          tgt_d   = tgt_now;
        end
      end
      RUN: begin
        if (ev && gate_a) begin
          if (acc_q == ACC_MAX) sat_d = 1'b1;
          else acc_d = acc_q + 32'd1;
        end
`ifdef GATED_DET_DARK_COUNT_EN
        if (ev && !gate_a && dark_q != ACC_MAX)
          dark_d = dark_q + 32'd1;
`endif
        if (wend) begin
          if (win_q + 16'd1 == tgt_q) begin
            pend_d    = 1'b1;
            res_cnt_d = acc_d;
            res_sat_d = sat_d;
`ifdef GATED_DET_DARK_COUNT_EN
            res_dark_d = dark_d;
            dark_d     = '0;
`endif
            acc_d = '0;
            sat_d = 1'b0;
            win_d = '0;
            tgt_d = tgt_now;
          end else begin
            win_d = win_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_comb begin
    count_data_d  = count_data_q;
    count_sat_d   = count_sat_q;
    count_valid_d = count_valid_q;
    overrun_d     = overrun_q;
`ifdef GATED_DET_DARK_COUNT_EN
    dark_data_d   = dark_data_q;
`endif
    if (count_valid_q && count_ready) count_valid_d = 1'b0;
    if (pend_q) begin
      if (!count_valid_q || count_ready) begin
        count_data_d  = res_cnt_q;
        count_sat_d   = res_sat_q;
        count_valid_d = 1'b1;
`ifdef GATED_DET_DARK_COUNT_EN
        dark_data_d   = res_dark_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      det_sync_q    <= '0;
      gate_sync_q   <= '0;
      det_edge_q    <= 1'b0;
      gate_dly_q    <= 1'b0;
      state_q       <= IDLE;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      win_q         <= '0;
      tgt_q         <= 16'd1;
      pend_q        <= 1'b0;
      res_cnt_q     <= '0;
      res_sat_q     <= 1'b0;
      count_data_q  <= '0;
      count_sat_q   <= 1'b0;
      count_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef GATED_DET_DARK_COUNT_EN
      dark_q        <= '0;
      res_dark_q    <= '0;
      dark_data_q   <= '0;
`endif
    end else begin
      det_sync_q    <= det_sync_d;
      gate_sync_q   <= gate_sync_d;
      det_edge_q    <= det_edge_d;
      gate_dly_q    <= gate_dly_d;
      state_q       <= state_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      win_q         <= win_d;
      tgt_q         <= tgt_d;
      pend_q        <= pend_d;
      res_cnt_q     <= res_cnt_d;
      res_sat_q     <= res_sat_d;
      count_data_q  <= count_data_d;
      count_sat_q   <= count_sat_d;
      count_valid_q <= count_valid_d;
      overrun_q     <= overrun_d;
`ifdef GATED_DET_DARK_COUNT_EN
      dark_q        <= dark_d;
      res_dark_q    <= res_dark_d;
      dark_data_q   <= dark_data_d;
`endif
    end
  end

  assign count_data  = count_data_q;
  assign count_sat   = count_sat_q;
  assign count_valid = count_valid_q;
  assign overrun     = overrun_q;
`ifdef GATED_DET_DARK_COUNT_EN
  assign dark_data   = dark_data_q;
`endif

endmodule

// File: tb/tb_gated_det_counter.sv
// Bench for gated_det_counter: vector table, corner sequences, random blocks.
// Dark-count outputs are checked when GATED_DET_DARK_COUNT_EN is defined.
module tb_gated_det_counter;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        det_gate = 1'b0;
  logic        det_in = 1'b0;
  logic [15:0] integ_periods = '0;
  logic        count_ready = 1'b0;
  logic [31:0] count_data;
  logic        count_sat;
  logic        count_valid;
  logic        overrun;
`ifdef GATED_DET_DARK_COUNT_EN
  logic [31:0] dark_data;
`endif

  gated_det_counter #(.SYNC_STAGES(N)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .det_gate(det_gate),
    .det_in(det_in),
    .integ_periods(integ_periods),
    .count_data(count_data),
    .count_sat(count_sat),
    .count_valid(count_valid),
    .count_ready(count_ready),
    .overrun(overrun)
`ifdef GATED_DET_DARK_COUNT_EN
    ,
    .dark_data(dark_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ip;
    int          nw;
    int          nin;
    int          nout;
    int          nout0;
    logic [31:0] exp_cnt;
    logic [31:0] exp_dark;
  } vec_t;

  vec_t        vecs[5];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] expd_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitors transfers while enabled, then advances one cycle
  task automatic tick();
    logic [31:0] e;
    logic [31:0] ed;
    if (mon_en && count_valid && count_ready) begin
      if (exp_q.size() == 0) begin
        chk("result_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        e  = exp_q.pop_front();
        ed = expd_q.pop_front();
        chk("mon_count_data", count_data, e);
        chk("mon_count_sat", {31'd0, count_sat}, 32'd0);
`ifdef GATED_DET_DARK_COUNT_EN
        chk("mon_dark_data", dark_data, ed);
`else
        ed = '0;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    det_in = 1'b1;
    tick();
    tick();
    det_in = 1'b0;
    tick();
    tick();
  endtask

  // gap with out-of-gate pulses, then a gate holding nin pulses
  task automatic send_window(input int nin, input int nout);
    repeat (4) tick();
    repeat (nout) pulse();
    det_gate = 1'b1;
    tick();
    tick();
    repeat (nin) pulse();
    tick();
    tick();
    det_gate = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 40 && !count_valid; k++) tick();
    chk(nm, {31'd0, count_valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    det_gate = 1'b0;
    det_in = 1'b0;
    count_ready = 1'b0;
    integ_periods = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int ipl[6];
    int sum_in;
    int sum_out;
    int nw;
    int nin;
    int nout;

    vecs[0] = '{1, 1, 3, 0, 0, 32'd3, 32'd0};
    vecs[1] = '{4, 4, 2, 1, 1, 32'd8, 32'd5};
    vecs[2] = '{0, 1, 4, 2, 0, 32'd4, 32'd2};
    vecs[3] = '{3, 3, 0, 1, 0, 32'd0, 32'd3};
    vecs[4] = '{2, 2, 5, 0, 2, 32'd10, 32'd2};

    #1;
    do_reset();
    chk("rst_count_data", count_data, 32'd0);
    chk("rst_count_sat", {31'd0, count_sat}, 32'd0);
    chk("rst_count_valid", {31'd0, count_valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
`ifdef GATED_DET_DARK_COUNT_EN
    chk("rst_dark_data", dark_data, 32'd0);
`endif

    // single window, latency from gate fall to valid
    integ_periods = 16'd1;
    enable = 1'b1;
    send_window(3, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (count_valid) begin
        lat = k;
        break;
      end
    end
    chk("valid_latency", lat, N + 2);
    chk("lat_count_data", count_data, 32'd3);
    chk("lat_count_sat", {31'd0, count_sat}, 32'd0);
    count_ready = 1'b1;
    tick();
    count_ready = 1'b0;
    chk("valid_drop", {31'd0, count_valid}, 32'd0);

    // enable raised mid-gate: partial window must be ignored
    enable = 1'b0;
    repeat (3) tick();
    det_gate = 1'b1;
    tick();
    tick();
    enable = 1'b1;
    pulse();
    pulse();
    tick();
    det_gate = 1'b0;
    send_window(3, 0);
    wait_valid("partial_valid");
    chk("partial_count", count_data, 32'd3);
    count_ready = 1'b1;
    tick();
    count_ready = 1'b0;
    chk("partial_drain", {31'd0, count_valid}, 32'd0);

    // overrun: second block dropped while first unconsumed
    do_reset();
    integ_periods = 16'd1;
    enable = 1'b1;
    send_window(5, 0);
    wait_valid("ovr_valid");
    chk("ovr_first", count_data, 32'd5);
    send_window(7, 0);
    repeat (6) tick();
    chk("ovr_hold_data", count_data, 32'd5);
    chk("ovr_hold_valid", {31'd0, count_valid}, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    count_ready = 1'b1;
    tick();
    count_ready = 1'b0;
    chk("ovr_valid_drop", {31'd0, count_valid}, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // publish in the same cycle the old result is taken
    do_reset();
    integ_periods = 16'd1;
    enable = 1'b1;
    send_window(2, 0);
    wait_valid("same_valid");
    chk("same_first", count_data, 32'd2);
    send_window(6, 0);
    repeat (N + 1) tick();
    count_ready = 1'b1;
    tick();
    count_ready = 1'b0;
    chk("same_valid_kept", {31'd0, count_valid}, 32'd1);
    chk("same_new_data", count_data, 32'd6);
    chk("same_no_overrun", {31'd0, overrun}, 32'd0);
    count_ready = 1'b1;
    tick();
    count_ready = 1'b0;

    // vector table, ready held high, results via monitor
    for (int v = 0; v < 5; v++) begin
      enable = 1'b0;
      repeat (3) tick();
      integ_periods = 16'(vecs[v].ip);
      count_ready = 1'b1;
      mon_en = 1'b1;
      enable = 1'b1;
      exp_q.push_back(vecs[v].exp_cnt);
      expd_q.push_back(vecs[v].exp_dark);
      for (int w = 0; w < vecs[v].nw; w++)
        send_window(vecs[v].nin,
                    vecs[v].nout + ((w == 0) ? vecs[v].nout0 : 0));
      repeat (12) tick();
      chk("vec_results_left", 32'(exp_q.size()), 32'd0);
    end

    // random blocks against an arithmetic model
    mon_en = 1'b0;
    do_reset();
    exp_q.delete();
    expd_q.delete();
    for (int b = 0; b < 6; b++) ipl[b] = $urandom_range(0, 3);
    integ_periods = 16'(ipl[0]);
    count_ready = 1'b1;
    mon_en = 1'b1;
    enable = 1'b1;
    for (int b = 0; b < 6; b++) begin
      nw = (ipl[b] == 0) ? 1 : ipl[b];
      sum_in = 0;
      sum_out = 0;
      for (int w = 0; w < nw; w++) begin
        nin = $urandom_range(0, 4);
        nout = $urandom_range(0, 3);
        sum_in += nin;
        sum_out += nout;
        send_window(nin, nout);
        if (w == 0 && b < 5) integ_periods = 16'(ipl[b + 1]);
      end
      exp_q.push_back(32'(sum_in));
      expd_q.push_back(32'(sum_out));
    end
    repeat (12) tick();
    chk("rand_results_left", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // saturation with integ_periods = 0
    do_reset();
    integ_periods = 16'd0;
    enable = 1'b1;
    repeat (4) tick();
    det_gate = 1'b1;
    tick();
    tick();
    tick();
    force dut.acc_d = 32'hFFFF_FFFE;
    tick();
    release dut.acc_d;
    pulse();
    pulse();
    pulse();
    tick();
    det_gate = 1'b0;
    wait_valid("sat_valid");
    chk("sat_count_data", count_data, 32'hFFFF_FFFF);
    chk("sat_flag", {31'd0, count_sat}, 32'd1);

    // reset mid-block clears everything next cycle
    repeat (4) tick();
    det_gate = 1'b1;
    pulse();
    rst = 1'b1;
    tick();
    chk("midrst_count_data", count_data, 32'd0);
    chk("midrst_count_sat", {31'd0, count_sat}, 32'd0);
    chk("midrst_count_valid", {31'd0, count_valid}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    det_gate = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
